updown_mod_counter: RTL and testbench

Parametrised synchronous up/down modulo-N counter with parallel load, free-running or one-shot mode, and a terminal-count output for cascading. Successor to the 4-bit ripple up counter: all flops share one clock, so there is no ripple settling. Used as a general-purpose event and interval counter in datapath and timer blocks.

---
 rtl/updown_mod_counter.sv | 107 ++++++++++
 tb/tb_updown_mod_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo-MODULUS counter with clamped parallel load, one-shot halt and terminal count.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             up,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS out of range for WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("updown_mod_counter: RESET_VAL must be below MODULUS");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_mod_counter: PRESCALE must be at least 1");
    end

    typedef enum logic {RUN, HALT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_next;
    logic             done_next;
    logic             step;
    logic             at_term;

`ifdef COUNTER_PRESCALE_EN
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre, pre_next;
    assign step = (pre == PMAX);
`else
    assign step = 1'b1;
`endif

    assign at_term = up ? (q == MAX) : (q == '0);
    assign tc      = ~rst & t & step & (state == RUN) & at_term;
    assign q_bar   = ~q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_Q;
            state <= RUN;
            done  <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
            pre   <= '0;
`endif
        end else begin
            q     <= q_next;
            state <= state_next;
            done  <= done_next;
`ifdef COUNTER_PRESCALE_EN
            pre   <= pre_next;
`endif
        end
    end

    always_comb begin
        q_next     = q;
        state_next = state;
        done_next  = done;
`ifdef COUNTER_PRESCALE_EN
        pre_next   = pre;
`endif
        if (load) begin
            // Out-of-range load values saturate to the top of the count range.
            q_next     = (d > MAX) ? MAX : d;
            state_next = RUN;
            done_next  = 1'b0;
`ifdef COUNTER_PRESCALE_EN
            pre_next   = '0;
`endif
        end else if (state == RUN && t) begin
`ifdef COUNTER_PRESCALE_EN
            pre_next = step ? '0 : pre + 1'b1;
`endif
            if (step) begin
                if (at_term && mode) begin
                    state_next = HALT;
                    done_next  = 1'b1;
                end else if (up) begin
                    q_next = (q == MAX) ? '0 : q + 1'b1;
                end else begin
                    q_next = (q == '0) ? MAX : q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10) against an integer arithmetic model.
// Build with COUNTER_PRESCALE_EN defined to exercise the PRESCALE=3 prescaler.
module tb_updown_mod_counter;

    localparam int W  = 4;
    localparam int M  = 10;
    localparam int RV = 0;
    localparam int P  = 3;
`ifdef COUNTER_PRESCALE_EN
    localparam bit PRE_ON = 1'b1;
`else
    localparam bit PRE_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0, t = 1'b0, up = 1'b1, mode = 1'b0, load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q, q_bar;
    logic         tc, done;

    int checks = 0;
    int fails  = 0;

    // Reference model: count value as plain integer, halted flag, done flag, enabled-cycle phase.
    int mq   = RV;
    int mpre = 0;
    bit mhalt = 1'b0;
    bit mdone = 1'b0;

    updown_mod_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(RV), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .t(t), .up(up), .mode(mode), .load(load), .d(d),
        .q(q), .q_bar(q_bar), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit m_step();
        return PRE_ON ? (mpre == P - 1) : 1'b1;
    endfunction

    function automatic bit m_tc();
        bit term;
        term = up ? (mq == M - 1) : (mq == 0);
        return !rst && t && !mhalt && m_step() && term;
    endfunction

    function automatic logic [W-1:0] m_qbar();
        logic [W-1:0] v;
        v = W'(mq);
        return ~v;
    endfunction

    task automatic apply(input bit r, input bit tt, input bit u, input bit md, input bit l, input int dv);
        @(negedge clk);
        rst = r; t = tt; up = u; mode = md; load = l; d = W'(dv);
        #1;
    endtask

    task automatic tick();
        bit s, term;
        @(posedge clk);
        if (rst) begin
            mq = RV; mhalt = 1'b0; mdone = 1'b0; mpre = 0;
        end else if (load) begin
            mq = (int'(d) > M - 1) ? M - 1 : int'(d);
            mhalt = 1'b0; mdone = 1'b0; mpre = 0;
        end else if (!mhalt && t) begin
            s    = m_step();
            mpre = PRE_ON ? (mpre + 1) % P : 0;
            if (s) begin
                term = up ? (mq == M - 1) : (mq == 0);
                if (term && mode) begin
                    mhalt = 1'b1; mdone = 1'b1;
                end else begin
                    mq = up ? (mq + 1) % M : (mq + M - 1) % M;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1, 1, 0, 0, 1, 5);
        checks++; if (tc !== 1'b0) begin fails++; $display("FAIL reset_tc_pre got=%b exp=0", tc); end
        tick();
        checks++; if (q !== W'(RV)) begin fails++; $display("FAIL reset_q got=%0d exp=%0d", q, RV); end
        checks++; if (q_bar !== 4'hF) begin fails++; $display("FAIL reset_qbar got=%h exp=f", q_bar); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        // q=0 counting down would be terminal, but rst must hold tc low.
        checks++; if (tc !== 1'b0) begin fails++; $display("FAIL reset_tc_hold got=%b exp=0", tc); end
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12 * (PRE_ON ? P : 1); i++) begin
            apply(0, 1, 1, 0, 0, 0);
            checks++; if (q !== W'(mq)) begin fails++; $display("FAIL wrap_q i=%0d got=%0d exp=%0d", i, q, mq); end
            checks++; if (tc !== m_tc()) begin fails++; $display("FAIL wrap_tc i=%0d got=%b exp=%b", i, tc, m_tc()); end
            checks++; if (q_bar !== m_qbar()) begin fails++; $display("FAIL wrap_qbar i=%0d got=%h exp=%h", i, q_bar, m_qbar()); end
            tick();
        end
        checks++; if (q !== W'(mq)) begin fails++; $display("FAIL wrap_end got=%0d exp=%0d", q, mq); end
    endtask

    task automatic test_down();
        apply(0, 0, 1, 0, 1, 2);
        tick();
        checks++; if (q !== 4'd2) begin fails++; $display("FAIL down_load got=%0d exp=2", q); end
        for (int i = 0; i < 5 * (PRE_ON ? P : 1); i++) begin
            apply(0, 1, 0, 0, 0, 0);
            checks++; if (q !== W'(mq)) begin fails++; $display("FAIL down_q i=%0d got=%0d exp=%0d", i, q, mq); end
            checks++; if (tc !== m_tc()) begin fails++; $display("FAIL down_tc i=%0d got=%b exp=%b", i, tc, m_tc()); end
            tick();
        end
    endtask

    task automatic test_oneshot();
        apply(0, 0, 1, 1, 1, 7);
        tick();
        for (int i = 0; i < 6 * (PRE_ON ? P : 1); i++) begin
            apply(0, 1, 1, 1, 0, 0);
            checks++; if (q !== W'(mq)) begin fails++; $display("FAIL oneshot_q i=%0d got=%0d exp=%0d", i, q, mq); end
            checks++; if (tc !== m_tc()) begin fails++; $display("FAIL oneshot_tc i=%0d got=%b exp=%b", i, tc, m_tc()); end
            checks++; if (done !== mdone) begin fails++; $display("FAIL oneshot_done i=%0d got=%b exp=%b", i, done, mdone); end
            tick();
        end
        checks++; if (done !== 1'b1 || q !== 4'd9) begin fails++; $display("FAIL oneshot_halt q=%0d done=%b exp q=9 done=1", q, done); end
        // Dropping mode must not release HALT.
        apply(0, 1, 1, 0, 0, 0);
        checks++; if (tc !== 1'b0) begin fails++; $display("FAIL halt_tc got=%b exp=0", tc); end
        tick();
        checks++; if (q !== 4'd9 || done !== 1'b1) begin fails++; $display("FAIL halt_hold q=%0d done=%b exp q=9 done=1", q, done); end
        apply(0, 1, 1, 1, 1, 3);
        tick();
        checks++; if (q !== 4'd3 || done !== 1'b0) begin fails++; $display("FAIL oneshot_reload q=%0d done=%b exp q=3 done=0", q, done); end
        for (int i = 0; i < 2 * (PRE_ON ? P : 1); i++) begin
            apply(0, 1, 1, 1, 0, 0);
            tick();
            checks++; if (q !== W'(mq)) begin fails++; $display("FAIL oneshot_resume i=%0d got=%0d exp=%0d", i, q, mq); end
        end
    endtask

    task automatic test_clamp_priority();
        apply(0, 1, 1, 0, 1, 15);
        tick();
        checks++; if (q !== 4'd9) begin fails++; $display("FAIL clamp_q got=%0d exp=9", q); end
        apply(0, 1, 1, 1, 0, 0);
        tick();
        apply(1, 1, 1, 0, 1, 5);
        tick();
        checks++; if (q !== W'(RV) || done !== 1'b0) begin fails++; $display("FAIL rst_over_load q=%0d done=%b exp q=%0d done=0", q, done, RV); end
    endtask

    task automatic test_gating();
        apply(0, 0, 1, 0, 1, 2);
        tick();
        while (mq != 4) begin
            apply(0, 1, 1, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 0, 0, 0);
            checks++; if (tc !== 1'b0) begin fails++; $display("FAIL gate_tc i=%0d got=%b exp=0", i, tc); end
            tick();
            checks++; if (q !== 4'd4) begin fails++; $display("FAIL gate_hold i=%0d got=%0d exp=4", i, q); end
        end
        for (int i = 0; i < (PRE_ON ? P : 1); i++) begin
            apply(0, 1, 0, 0, 0, 0);
            tick();
        end
        checks++; if (q !== 4'd3) begin fails++; $display("FAIL dir_flip got=%0d exp=3", q); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            apply(($urandom % 32) == 0, ($urandom % 4) != 0, $urandom % 2, ($urandom % 4) == 0,
                  ($urandom % 8) == 0, int'($urandom % 16));
            checks++; if (tc !== m_tc()) begin fails++; $display("FAIL rand_tc i=%0d got=%b exp=%b", i, tc, m_tc()); end
            tick();
            checks++; if (q !== W'(mq)) begin fails++; $display("FAIL rand_q i=%0d got=%0d exp=%0d", i, q, mq); end
            checks++; if (q_bar !== m_qbar()) begin fails++; $display("FAIL rand_qbar i=%0d got=%h exp=%h", i, q_bar, m_qbar()); end
            checks++; if (done !== mdone) begin fails++; $display("FAIL rand_done i=%0d got=%b exp=%b", i, done, mdone); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_down();
        test_oneshot();
        test_clamp_priority();
        test_gating();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
